tc_ram_dual_port: RTL and testbench

//  Parametrised RAM with one read/write port (0) and one read-only port (1).

---
 rtl/tc_ram_dual_port.sv | 192 +++++++++++++++++++
 tb/tb_tc_ram_dual_port.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_ram_dual_port.sv
// tc_ram_dual_port
//   General-purpose RAM with one read/write port (port 0) and one read-only
//   port (port 1). Writes use per-byte enables. Reads are registered, have a
//   one-cycle latency, and come with a valid flag. When CLEAR_ON_RESET is set,
//   every word is zeroed by a sweep that runs after reset, and busy is high
//   while it runs.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   load0       port 0 read request
//   save0       port 0 write request
//   address0    port 0 word address
//   in0         port 0 write data
//   mask0       port 0 byte enables; bit k covers in0[8k+7:8k]
//   out0        port 0 registered read data
//   out0_valid  out0 holds data from a load0 accepted on the previous edge
//   load1       port 1 read request
//   address1    port 1 word address
//   out1        port 1 registered read data
//   out1_valid  out1 holds data from a load1 accepted on the previous edge
//   busy        clear sweep in progress; all requests are ignored
module tc_ram_dual_port #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load0,
    input  logic                 save0,
    input  logic [ADDR_W-1:0]    address0,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH/8-1:0]   mask0,
    output logic [WIDTH-1:0]     out0,
    output logic                 out0_valid,
    input  logic                 load1,
    input  logic [ADDR_W-1:0]    address1,
    output logic [WIDTH-1:0]     out1,
    output logic                 out1_valid,
    output logic                 busy
);

    localparam int                BYTES     = WIDTH / 8;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]    out0_q, out0_d;
    logic [WIDTH-1:0]    out1_q, out1_d;
    logic                out0_valid_q, out0_valid_d;
    logic                out1_valid_q, out1_valid_d;

    logic [WIDTH-1:0]    mem [DEPTH];

    logic                ready;
    logic                clear_en;
    logic                write_en;
    logic                in_range0;
    logic                in_range1;
    logic [ADDR_W-1:0]   idx0;
    logic [ADDR_W-1:0]   idx1;
    logic [WIDTH-1:0]    word0;
    logic [WIDTH-1:0]    word1;
    logic [WIDTH-1:0]    merged;
    logic [WIDTH-1:0]    rd0;
    logic [WIDTH-1:0]    rd1;

    // Clear sweep: one word per cycle, leaving for READY on the same edge
    // that clears the last word. READY is only left through reset.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        clear_en = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_en = 1'b1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    count_d = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign ready = (state_q == ST_READY);
    assign busy  = ~ready;

    // Out-of-range addresses never touch the array: the index is clamped so
    // the lookup stays legal and the result is then masked off.
    always_comb begin
        in_range0 = ({1'b0, address0} < DEPTH_EXT);
        in_range1 = ({1'b0, address1} < DEPTH_EXT);
        idx0      = in_range0 ? address0 : '0;
        idx1      = in_range1 ? address1 : '0;
        word0     = mem[idx0];
        word1     = mem[idx1];
        write_en  = ready & save0 & in_range0;
    end

    // Write-first: a read of the word being written sees the merged result,
    // on either port.
    always_comb begin
        merged = word0;
        for (int k = 0; k < BYTES; k++) begin
            if (mask0[k]) begin
                merged[8*k +: 8] = in0[8*k +: 8];
            end
        end

        rd0 = '0;
        if (in_range0) begin
            rd0 = write_en ? merged : word0;
        end

        rd1 = '0;
        if (in_range1) begin
            rd1 = (write_en && (address1 == address0)) ? merged : word1;
        end
    end

    // Read registers hold their value unless a read is accepted; valid only
    // marks the cycle right after an accepted read.
    always_comb begin
        out0_d       = out0_q;
        out1_d       = out1_q;
        out0_valid_d = 1'b0;
        out1_valid_d = 1'b0;
        if (ready && load0) begin
            out0_d       = rd0;
            out0_valid_d = 1'b1;
        end
        if (ready && load1) begin
            out1_d       = rd1;
            out1_valid_d = 1'b1;
        end
    end

    // Control and output registers. Reset restarts the sweep from word 0
    // but never writes the array directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            count_q      <= '0;
            out0_q       <= '0;
            out1_q       <= '0;
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
        end
    end

    // Storage array: sweep writes and port 0 byte writes are mutually
    // exclusive because writes are only accepted in READY.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[count_q] <= '0;
        end else if (write_en) begin
            for (int k = 0; k < BYTES; k++) begin
                if (mask0[k]) begin
                    mem[idx0][8*k +: 8] <= in0[8*k +: 8];
                end
            end
        end
    end

    assign out0       = out0_q;
    assign out1       = out1_q;
    assign out0_valid = out0_valid_q;
    assign out1_valid = out1_valid_q;

endmodule

// File: tb/tb_tc_ram_dual_port.sv
// tb_tc_ram_dual_port
//   Bench for tc_ram_dual_port. Instance "a" is 16 bits x 256 words and
//   carries most scenarios against a reference memory model; instance "b"
//   is 8 bits x 200 words and covers out-of-range addresses.
module tb_tc_ram_dual_port;

    typedef struct {
        bit          l0;
        bit          s0;
        logic [7:0]  ad0;
        logic [15:0] d;
        logic [1:0]  m;
        bit          l1;
        logic [7:0]  ad1;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_load0, a_save0, a_load1;
    logic [7:0]  a_address0, a_address1;
    logic [15:0] a_in0;
    logic [1:0]  a_mask0;
    logic [15:0] a_out0, a_out1;
    logic        a_out0_valid, a_out1_valid, a_busy;

    logic        b_load0, b_save0, b_load1;
    logic [7:0]  b_address0, b_address1;
    logic [7:0]  b_in0;
    logic [0:0]  b_mask0;
    logic [7:0]  b_out0, b_out1;
    logic        b_out0_valid, b_out1_valid, b_busy;

    int          total = 0;
    int          bad = 0;

    logic [15:0] model [256];
    logic [15:0] last0, last1;
    bit          a_ready;
    logic [16:0] exp0 [$];
    logic [16:0] exp1 [$];
    logic [16:0] e0, e1;

    tc_ram_dual_port #(.WIDTH(16), .DEPTH(256), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst),
        .load0(a_load0), .save0(a_save0), .address0(a_address0),
        .in0(a_in0), .mask0(a_mask0), .out0(a_out0), .out0_valid(a_out0_valid),
        .load1(a_load1), .address1(a_address1), .out1(a_out1),
        .out1_valid(a_out1_valid), .busy(a_busy)
    );

    tc_ram_dual_port #(.WIDTH(8), .DEPTH(200), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst(rst),
        .load0(b_load0), .save0(b_save0), .address0(b_address0),
        .in0(b_in0), .mask0(b_mask0), .out0(b_out0), .out0_valid(b_out0_valid),
        .load1(b_load1), .address1(b_address1), .out1(b_out1),
        .out1_valid(b_out1_valid), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic a_idle();
        a_load0 = 1'b0; a_save0 = 1'b0; a_load1 = 1'b0;
        a_address0 = '0; a_address1 = '0; a_in0 = '0; a_mask0 = '0;
    endtask

    task automatic b_idle();
        b_load0 = 1'b0; b_save0 = 1'b0; b_load1 = 1'b0;
        b_address0 = '0; b_address1 = '0; b_in0 = '0; b_mask0 = '0;
    endtask

    // Drives one request on instance a, updates the reference memory
    // (writes land before same-cycle reads) and queues the expected outputs.
    task automatic issue_a(input op_t op);
        logic [15:0] w;
        a_load0 = op.l0; a_save0 = op.s0; a_address0 = op.ad0;
        a_in0 = op.d; a_mask0 = op.m; a_load1 = op.l1; a_address1 = op.ad1;
        if (a_ready) begin
            if (op.s0) begin
                w = model[op.ad0];
                for (int k = 0; k < 2; k++) begin
                    if (op.m[k]) w[8*k +: 8] = op.d[8*k +: 8];
                end
                model[op.ad0] = w;
            end
            if (op.l0) last0 = model[op.ad0];
            if (op.l1) last1 = model[op.ad1];
            exp0.push_back({op.l0, last0});
            exp1.push_back({op.l1, last1});
        end else begin
            exp0.push_back({1'b0, last0});
            exp1.push_back({1'b0, last1});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_idle();
        b_idle();
        a_ready = 1'b0;
        last0 = '0;
        last1 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a_out0, a_out0_valid, a_out1, a_out1_valid} !== 34'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs_a: got %h %b %h %b want all zero",
                     a_out0, a_out0_valid, a_out1, a_out1_valid);
        end
        total++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_busy_a: got %b want 1", a_busy);
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            if (i == 199) begin
                total++;
                if (b_busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL sweep_busy_b_199: got %b want 1", b_busy);
                end
            end
            if (i == 200) begin
                total++;
                if (b_busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL sweep_busy_b_200: got %b want 0", b_busy);
                end
            end
            if (i == 255) begin
                total++;
                if (a_busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL sweep_busy_a_255: got %b want 1", a_busy);
                end
            end
            if (i == 256) begin
                total++;
                if (a_busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL sweep_busy_a_256: got %b want 0", a_busy);
                end
            end
        end
        for (int i = 0; i < 256; i++) model[i] = '0;
        a_ready = 1'b1;
    endtask

    task automatic test_sweep_readback();
        op_t op;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            op = '{1'b1, 1'b0, 8'(i), 16'h0, 2'b00, 1'b1, 8'(255 - i)};
            issue_a(op);
            @(posedge clk);
            #1;
            e0 = exp0.pop_front();
            e1 = exp1.pop_front();
            total += 2;
            if ({a_out0_valid, a_out0} !== e0) begin
                bad++;
                $display("[TB] FAIL readback_p0 addr %0d: got %h want %h", i, {a_out0_valid, a_out0}, e0);
            end
            if ({a_out1_valid, a_out1} !== e1) begin
                bad++;
                $display("[TB] FAIL readback_p1 addr %0d: got %h want %h", 255 - i, {a_out1_valid, a_out1}, e1);
            end
        end
        @(negedge clk) a_idle();
    endtask

    task automatic test_byte_mask();
        op_t ops [$];
        ops.push_back('{1'b0, 1'b1, 8'd5, 16'hABCD, 2'b11, 1'b0, 8'd0});
        ops.push_back('{1'b0, 1'b1, 8'd5, 16'h1234, 2'b01, 1'b1, 8'd5});
        ops.push_back('{1'b1, 1'b0, 8'd5, 16'h0000, 2'b00, 1'b0, 8'd0});
        ops.push_back('{1'b0, 1'b1, 8'd6, 16'h9999, 2'b00, 1'b1, 8'd6});
        for (int i = 0; i < ops.size(); i++) begin
            @(negedge clk);
            issue_a(ops[i]);
            @(posedge clk);
            #1;
            e0 = exp0.pop_front();
            e1 = exp1.pop_front();
            total += 2;
            if ({a_out0_valid, a_out0} !== e0) begin
                bad++;
                $display("[TB] FAIL byte_mask_p0 step %0d: got %h want %h", i, {a_out0_valid, a_out0}, e0);
            end
            if ({a_out1_valid, a_out1} !== e1) begin
                bad++;
                $display("[TB] FAIL byte_mask_p1 step %0d: got %h want %h", i, {a_out1_valid, a_out1}, e1);
            end
            if (i == 2) begin
                total++;
                if (a_out0 !== 16'hAB34) begin
                    bad++;
                    $display("[TB] FAIL byte_mask_value: got %h want AB34", a_out0);
                end
            end
        end
        @(negedge clk) a_idle();
    endtask

    task automatic test_collision();
        op_t ops [$];
        ops.push_back('{1'b1, 1'b1, 8'd3, 16'h005A, 2'b01, 1'b1, 8'd3});
        ops.push_back('{1'b1, 1'b1, 8'd3, 16'hC300, 2'b10, 1'b1, 8'd4});
        ops.push_back('{1'b0, 1'b1, 8'd3, 16'h7711, 2'b11, 1'b1, 8'd3});
        for (int i = 0; i < ops.size(); i++) begin
            @(negedge clk);
            issue_a(ops[i]);
            @(posedge clk);
            #1;
            e0 = exp0.pop_front();
            e1 = exp1.pop_front();
            total += 2;
            if ({a_out0_valid, a_out0} !== e0) begin
                bad++;
                $display("[TB] FAIL collision_p0 step %0d: got %h want %h", i, {a_out0_valid, a_out0}, e0);
            end
            if ({a_out1_valid, a_out1} !== e1) begin
                bad++;
                $display("[TB] FAIL collision_p1 step %0d: got %h want %h", i, {a_out1_valid, a_out1}, e1);
            end
            if (i == 0) begin
                total++;
                if ({a_out0_valid, a_out0, a_out1_valid, a_out1} !== {1'b1, 16'h005A, 1'b1, 16'h005A}) begin
                    bad++;
                    $display("[TB] FAIL collision_value: got %b %h %b %h want 1 005A 1 005A",
                             a_out0_valid, a_out0, a_out1_valid, a_out1);
                end
            end
        end
        @(negedge clk) a_idle();
    endtask

    task automatic test_port1_only();
        op_t ops [$];
        ops.push_back('{1'b0, 1'b1, 8'd7, 16'h7777, 2'b11, 1'b0, 8'd0});
        ops.push_back('{1'b1, 1'b0, 8'd5, 16'h0000, 2'b00, 1'b0, 8'd0});
        ops.push_back('{1'b0, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd7});
        ops.push_back('{1'b0, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b0, 8'd0});
        for (int i = 0; i < ops.size(); i++) begin
            @(negedge clk);
            issue_a(ops[i]);
            @(posedge clk);
            #1;
            e0 = exp0.pop_front();
            e1 = exp1.pop_front();
            total += 2;
            if ({a_out0_valid, a_out0} !== e0) begin
                bad++;
                $display("[TB] FAIL port1_only_p0 step %0d: got %h want %h", i, {a_out0_valid, a_out0}, e0);
            end
            if ({a_out1_valid, a_out1} !== e1) begin
                bad++;
                $display("[TB] FAIL port1_only_p1 step %0d: got %h want %h", i, {a_out1_valid, a_out1}, e1);
            end
        end
        @(negedge clk) a_idle();
    endtask

    task automatic test_random();
        op_t op;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            op.l0  = 1'($urandom);
            op.s0  = 1'($urandom);
            op.ad0 = 8'($urandom_range(0, 15));
            op.d   = 16'($urandom);
            op.m   = 2'($urandom);
            op.l1  = 1'($urandom);
            op.ad1 = 8'($urandom_range(0, 15));
            issue_a(op);
            @(posedge clk);
            #1;
            e0 = exp0.pop_front();
            e1 = exp1.pop_front();
            total += 2;
            if ({a_out0_valid, a_out0} !== e0) begin
                bad++;
                $display("[TB] FAIL random_p0 cycle %0d: got %h want %h", i, {a_out0_valid, a_out0}, e0);
            end
            if ({a_out1_valid, a_out1} !== e1) begin
                bad++;
                $display("[TB] FAIL random_p1 cycle %0d: got %h want %h", i, {a_out1_valid, a_out1}, e1);
            end
        end
        @(negedge clk) a_idle();
    endtask

    task automatic test_reset_mid_sweep();
        op_t op;
        @(negedge clk) rst = 1'b0;
        a_ready = 1'b0;
        #1;
        total++;
        if ({a_out0, a_out0_valid, a_out1, a_out1_valid, a_busy} !== 35'd1) begin
            bad++;
            $display("[TB] FAIL async_reset: got %h %b %h %b busy %b want zeros busy 1",
                     a_out0, a_out0_valid, a_out1, a_out1_valid, a_busy);
        end
        @(negedge clk) rst = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        total++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_sweep_busy: got %b want 1", a_busy);
        end
        a_save0 = 1'b1; a_address0 = 8'd20; a_in0 = 16'hBEEF; a_mask0 = 2'b11;
        a_load0 = 1'b1; a_load1 = 1'b1; a_address1 = 8'd20;
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            if (i == 50 || i == 256) begin
                total++;
                if ({a_out0_valid, a_out0, a_out1_valid, a_out1} !== 34'd0) begin
                    bad++;
                    $display("[TB] FAIL busy_ignore edge %0d: got %b %h %b %h want zeros",
                             i, a_out0_valid, a_out0, a_out1_valid, a_out1);
                end
            end
            if (i == 255) begin
                total++;
                if (a_busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL restart_busy_255: got %b want 1", a_busy);
                end
            end
            if (i == 256) begin
                total++;
                if (a_busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL restart_busy_256: got %b want 0", a_busy);
                end
            end
        end
        @(negedge clk) a_idle();
        for (int i = 0; i < 256; i++) model[i] = '0;
        last0 = '0;
        last1 = '0;
        a_ready = 1'b1;
        @(negedge clk);
        op = '{1'b1, 1'b0, 8'd20, 16'h0, 2'b00, 1'b1, 8'd7};
        issue_a(op);
        @(posedge clk);
        #1;
        e0 = exp0.pop_front();
        e1 = exp1.pop_front();
        total += 2;
        if ({a_out0_valid, a_out0} !== e0) begin
            bad++;
            $display("[TB] FAIL after_restart_p0: got %h want %h", {a_out0_valid, a_out0}, e0);
        end
        if ({a_out1_valid, a_out1} !== e1) begin
            bad++;
            $display("[TB] FAIL after_restart_p1: got %h want %h", {a_out1_valid, a_out1}, e1);
        end
        @(negedge clk) a_idle();
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        b_save0 = 1'b1; b_address0 = 8'd199; b_in0 = 8'h3C; b_mask0 = 1'b1;
        @(negedge clk);
        b_address0 = 8'd210; b_in0 = 8'hFF;
        @(negedge clk);
        b_save0 = 1'b0; b_load0 = 1'b1; b_address0 = 8'd210;
        b_load1 = 1'b1; b_address1 = 8'd199;
        @(posedge clk);
        #1;
        total += 2;
        if ({b_out0_valid, b_out0} !== {1'b1, 8'h00}) begin
            bad++;
            $display("[TB] FAIL oor_read_210: got %b %h want 1 00", b_out0_valid, b_out0);
        end
        if ({b_out1_valid, b_out1} !== {1'b1, 8'h3C}) begin
            bad++;
            $display("[TB] FAIL oor_word_199: got %b %h want 1 3C", b_out1_valid, b_out1);
        end
        @(negedge clk);
        b_address0 = 8'd199; b_address1 = 8'd230;
        @(posedge clk);
        #1;
        total += 2;
        if ({b_out0_valid, b_out0} !== {1'b1, 8'h3C}) begin
            bad++;
            $display("[TB] FAIL oor_p0_199: got %b %h want 1 3C", b_out0_valid, b_out0);
        end
        if ({b_out1_valid, b_out1} !== {1'b1, 8'h00}) begin
            bad++;
            $display("[TB] FAIL oor_p1_230: got %b %h want 1 00", b_out1_valid, b_out1);
        end
        @(negedge clk) b_idle();
    endtask

    initial begin
        $display("[TB] starting tc_ram_dual_port bench");
        test_reset();
        test_sweep_readback();
        test_byte_mask();
        test_collision();
        test_port1_only();
        test_random();
        test_reset_mid_sweep();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
